// File: rtl/secure_init_if.sv
// Status/strobe/data bus between secure_init_ctrl and its consumer, plus the
// configuration write port arbitrated against the secure-mode lock.
interface secure_init_if;
  logic        secure_in;
  logic        cfg_valid;
  logic [31:0] cfg_wdata;
  logic        cfg_ready;
  logic        cfg_err;
  logic        status;
  logic        strobe;
  logic [31:0] data;
  logic        secure_out;

  modport master (
    output secure_in, cfg_valid, cfg_wdata,
    input  cfg_ready, cfg_err, status, strobe, data, secure_out
  );

  modport slave (
    input  secure_in, cfg_valid, cfg_wdata,
    output cfg_ready, cfg_err, status, strobe, data, secure_out
  );
endinterface

// File: rtl/secure_init_ctrl.sv
// Timed bring-up sequencer for the secure status/strobe/data interface; owns
// every later update of the data word and rejects writes while secure mode is latched.
module secure_init_ctrl #(
  parameter int          STATUS_DLY = 9,
  parameter int          STROBE_DLY = 5,
  parameter logic [31:0] INIT_WORD  = 32'h0000_00FF
) (
  input logic          clk,
  input logic          rst2,
  input logic          rst1,
  secure_init_if.slave bus
);

  localparam int MAX_DLY = (STATUS_DLY > STROBE_DLY) ? STATUS_DLY : STROBE_DLY;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ARM   = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             status_q;
  logic             strobe_q;
  logic             secure_q;
  logic             err_q;
  logic [31:0]      data_q;
  logic             accept;
  logic             reject;

  // A write is only considered in READY with soft reset released, and never in
  // the strobe cycle, which keeps strobes at least one cycle apart.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if (state == S_READY && rst1 && bus.cfg_valid && !strobe_q) begin
      accept = !secure_q;
      reject = secure_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      state    <= S_HOLD;
      cnt      <= '0;
      status_q <= 1'b1;
      strobe_q <= 1'b0;
      secure_q <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else if (!rst1) begin
      // Soft reset deliberately leaves data_q untouched.
      state    <= S_HOLD;
      cnt      <= '0;
      status_q <= 1'b1;
      strobe_q <= 1'b0;
      secure_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= reject;
      case (state)
        S_HOLD: begin
          state    <= S_WAIT;
          cnt      <= CNT_W'(STATUS_DLY - 1);
          secure_q <= bus.secure_in;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state    <= S_ARM;
            cnt      <= CNT_W'(STROBE_DLY - 1);
            status_q <= 1'b0;
            data_q   <= INIT_WORD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ARM: begin
          if (cnt == '0) begin
            state    <= S_READY;
            strobe_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_READY: begin
          if (accept) begin
            data_q   <= bus.cfg_wdata;
            strobe_q <= 1'b1;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

  assign bus.cfg_ready  = accept;
  assign bus.cfg_err    = err_q;
  assign bus.status     = status_q;
  assign bus.strobe     = strobe_q;
  assign bus.data       = data_q;
  assign bus.secure_out = secure_q;

endmodule

// File: tb/tb_secure_init_ctrl.sv
// Self-checking bench for secure_init_ctrl: directed and random steps compared
// each cycle against a timeline model counting edges since the soft-reset release.
module tb_secure_init_ctrl;

  localparam int          SD   = 9;
  localparam int          ST   = 5;
  localparam logic [31:0] INIT = 32'h0000_00FF;

  logic clk = 1'b0;
  logic rst2;
  logic rst1;

  secure_init_if bus ();

  secure_init_ctrl #(.STATUS_DLY(SD), .STROBE_DLY(ST), .INIT_WORD(INIT)) dut (
    .clk  (clk),
    .rst2 (rst2),
    .rst1 (rst1),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: m_rel is the number of edges since the release edge (-1 while held).
  int          m_rel;
  logic        m_status, m_strobe, m_sec, m_err;
  logic [31:0] m_data;
  logic        prev_strobe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_hard_reset();
    m_rel    = -1;
    m_status = 1'b1;
    m_strobe = 1'b0;
    m_sec    = 1'b0;
    m_err    = 1'b0;
    m_data   = '0;
  endtask

  function automatic logic model_avail();
    return rst2 && rst1 && bus.cfg_valid && (m_rel >= SD + ST) && !m_strobe;
  endfunction

  task automatic check_outputs(input string ph);
    check({ph, "_status"}, 32'(bus.status), 32'(m_status));
    check({ph, "_strobe"}, 32'(bus.strobe), 32'(m_strobe));
    check({ph, "_data"}, bus.data, m_data);
    check({ph, "_secure_out"}, 32'(bus.secure_out), 32'(m_sec));
    check({ph, "_cfg_err"}, 32'(bus.cfg_err), 32'(m_err));
  endtask

  // One clock cycle: drive, check the combinational ready, advance model at the edge, check.
  task automatic step(input logic r2, input logic r1, input logic v,
                      input logic [31:0] wd, input logic si);
    logic acc, rej;
    rst2          = r2;
    rst1          = r1;
    bus.cfg_valid = v;
    bus.cfg_wdata = wd;
    bus.secure_in = si;
    if (!r2) model_hard_reset();
    #3;
    acc = model_avail() && !m_sec;
    rej = model_avail() && m_sec;
    check("cfg_ready", 32'(bus.cfg_ready), 32'(acc));
    if (!r2) check_outputs("in_rst2");
    prev_strobe = bus.strobe;
    @(posedge clk);
    if (r2) begin
      if (!r1) begin
        m_rel    = -1;
        m_status = 1'b1;
        m_strobe = 1'b0;
        m_sec    = 1'b0;
        m_err    = 1'b0;
      end else begin
        if (m_rel < 0) begin
          m_rel = 0;
          m_sec = si;
        end else if (m_rel < 1000) begin
          m_rel++;
        end
        m_status = (m_rel < SD);
        m_strobe = (m_rel == SD + ST) || acc;
        m_err    = rej;
        if (m_rel == SD) m_data = INIT;
        if (acc)         m_data = wd;
      end
    end
    #1;
    check_outputs("edge");
    check("no_double_strobe", 32'(prev_strobe && bus.strobe), 32'd0);
  endtask

  task automatic idle(input int n, input logic r1, input logic si);
    for (int i = 0; i < n; i++) step(1'b1, r1, 1'b0, 32'h0, si);
  endtask

  initial begin
    rst2          = 1'b0;
    rst1          = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_wdata = '0;
    bus.secure_in = 1'b0;
    model_hard_reset();
    @(posedge clk);
    #1;

    // Hard reset with noisy inputs: outputs must stay at reset values.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));

    // Cold boot, non-secure; then a write held for three cycles (accept, blocked, accept).
    idle(3, 1'b0, 1'b0);
    idle(SD + ST + 2, 1'b1, 1'b0);
    check("cold_boot_data", bus.data, INIT);
    step(1'b1, 1'b1, 1'b1, 32'hA5A5_1234, 1'b0);
    check("write1_data", bus.data, 32'hA5A5_1234);
    step(1'b1, 1'b1, 1'b1, 32'hA5A5_1234, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hA5A5_1234, 1'b0);
    idle(2, 1'b1, 1'b0);

    // Secure lock: write of 1 is rejected with an error pulse.
    idle(2, 1'b0, 1'b1);
    idle(SD + ST + 2, 1'b1, 1'b1);
    check("secure_latched", 32'(bus.secure_out), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h1, 1'b0);
    check("secure_err", 32'(bus.cfg_err), 32'd1);
    check("secure_data_kept", bus.data, INIT);
    idle(2, 1'b1, 1'b0);

    // Soft reset three cycles after status falls (mid-ARM), then full re-release.
    idle(2, 1'b0, 1'b0);
    idle(SD + 3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("arm_abort_status", 32'(bus.status), 32'd1);
    idle(SD + ST + 3, 1'b1, 1'b0);

    // Soft-reset data hold, with a write coinciding with rst1 low.
    step(1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
    idle(1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(2, 1'b0, 1'b0);
    check("hold_data", bus.data, 32'h55);
    idle(SD + ST + 2, 1'b1, 1'b0);

    // Random traffic with occasional soft resets and secure requests.
    for (int i = 0; i < 400; i++)
      step(1'b1, ($urandom_range(39) != 0), 1'($urandom_range(1)), $urandom,
           ($urandom_range(3) == 0));

    // Asynchronous hard reset mid-operation, then one more boot.
    step(1'b0, 1'b1, 1'b1, $urandom, 1'b1);
    idle(SD + ST + 4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
